iob_ram_fifo_ctrl: RTL
======================

// Module: iob_ram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives an external true-dual-port byte-enable RAM.
//  The RAM's port A is the write port and port B is the read port.
//  Sits directly upstream of the RAM and owns the pointers, the fill level and the flags.
//  Presents a push/pop FIFO interface to the producer and the consumer.
//  The RAM has 1-cycle read latency and read-first behaviour; it is instantiated outside this block.
// PARAMETERS
//  DATA_W  32  FIFO word width in bits; multiple of 8
//  ADDR_W  10  RAM address width; FIFO depth is 2**ADDR_W words
// PORTS
//  clk            in   1          clock; the only clock; also drives the RAM's clkA/clkB
//  rst            in   1          asynchronous, active-high reset
//  w_en           in   1          push request
//  w_data         in   DATA_W     push data
//  w_full         out  1          FIFO full
//  r_en           in   1          pop request
//  r_data         out  DATA_W     pop data
//  r_valid        out  1          r_data holds the word popped on the previous cycle
//  r_empty        out  1          FIFO empty
//  level          out  ADDR_W+1   number of words stored
//  overflow       out  1          sticky: a push was attempted while full
//  underflow      out  1          sticky: a pop was attempted while empty
//  ram_en_a       out  1          RAM port A enable
//  ram_we_a       out  DATA_W/8   RAM port A byte write enables
//  ram_addr_a     out  ADDR_W     RAM port A address (write pointer)
//  ram_din_a      out  DATA_W     RAM port A write data
//  ram_en_b       out  1          RAM port B enable
//  ram_addr_b     out  ADDR_W     RAM port B address (read pointer)
//  ram_dout_b     in   DATA_W     RAM port B read data
// BEHAVIOUR
//  Reset values (asynchronous): wptr=0, rptr=0, level=0, r_valid=0, overflow=0, underflow=0.
//   Consequently w_full=0 and r_empty=1 during and after reset.
//  Flags are combinational from the level register:
//   w_full  = (level == 2**ADDR_W)
//   r_empty = (level == 0)
//  Push accepted (push) = w_en & ~w_full.
//   RAM port A: ram_en_a=push, ram_we_a={DATA_W/8{push}}, ram_addr_a=wptr, ram_din_a=w_data.
//   The enable and address outputs are combinational.
//   wptr <= wptr+1 on push; wraps modulo 2**ADDR_W.
//  Pop accepted (pop) = r_en & ~r_empty.
//   RAM port B: ram_en_b=pop, ram_addr_b=rptr. rptr <= rptr+1 on pop; wraps modulo 2**ADDR_W.
//   r_valid <= pop. r_data = ram_dout_b, passed through.
//   Read latency: 1 cycle from the accepted pop to valid r_data.
//   r_data holds its value until the next pop, because the RAM output only updates when enabled.
//  Level update:
//   push only: level+1; pop only: level-1; both or neither: unchanged.
//  Simultaneous push and pop:
//   When full: pop accepted, push rejected (w_full is sampled before the update).
//   When empty: push accepted, pop rejected. The new word is poppable next cycle (no fall-through).
//   When neither full nor empty: both accepted, and wptr != rptr, so there is no RAM port collision.
//  Rejected requests:
//   A rejected push sets overflow; a rejected pop sets underflow.
//   Neither pointer nor level changes on a rejected request.
//   The sticky flags clear only on rst.
//  Reset mid-operation: pointers, level and flags return to their reset values immediately.
//   RAM contents are not cleared but become unreachable.
//   A pop in flight is dropped (r_valid=0).
// TESTING
//  1. Reset -> r_empty=1, w_full=0, level=0, r_valid=0; r_en=1 for 1 cycle -> underflow=1, ram_en_b=0.
//  2. Push 0xA0..0xA3, then pop 4 -> r_data 0xA0,0xA1,0xA2,0xA3 each 1 cycle after its pop;
//     level 4->0; r_empty=1 at the end.
//  3. Fill to 2**ADDR_W (ADDR_W=3: 8 words) -> w_full=1, level=8.
//     A further push -> overflow=1, wptr unchanged, ram_en_a=0.
//  4. Full, w_en=r_en=1 -> only the pop is accepted, level=7.
//     Empty, w_en=r_en=1 -> only the push is accepted, level=1.
//  5. Steady push+pop for 20 cycles at ADDR_W=3 -> pointers wrap, level constant,
//     data order preserved across the wrap.
//  6. Assert rst with level=5 and a pop in flight -> level=0, r_valid=0, flags cleared;
//     a subsequent push/pop returns the new data.

Source files
------------

// File: rtl/iob_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : iob_ram_fifo_ctrl
// Brief   : FIFO pointer/level/flag controller for an external dual-port RAM
// Revision: 1.0
// ============================================================================
module iob_ram_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [DATA_W-1:0]   w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  output logic                underflow,
  output logic                ram_en_a,
  output logic [DATA_W/8-1:0] ram_we_a,
  output logic [ADDR_W-1:0]   ram_addr_a,
  output logic [DATA_W-1:0]   ram_din_a,
  output logic                ram_en_b,
  output logic [ADDR_W-1:0]   ram_addr_b,
  input  logic [DATA_W-1:0]   ram_dout_b
);

  localparam logic [ADDR_W:0]   c_depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] c_ptrInc = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_lvlInc = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_level;
  logic              r_rdValid;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_push;
  logic              w_pop;

  // Flags come from the level register alone, so a simultaneous push/pop
  // sees the pre-update full/empty state.
  assign w_full  = (r_level == c_depth);
  assign r_empty = (r_level == '0);
  assign w_push  = w_en & ~w_full;
  assign w_pop   = r_en & ~r_empty;

  assign ram_en_a   = w_push;
  assign ram_we_a   = {(DATA_W/8){w_push}};
  assign ram_addr_a = r_wrPtr;
  assign ram_din_a  = w_data;
  assign ram_en_b   = w_pop;
  assign ram_addr_b = r_rdPtr;

  // RAM output only changes on an enabled read, so it holds the last pop.
  assign r_data    = ram_dout_b;
  assign r_valid   = r_rdValid;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_rdValid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_ptrInc;
      if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrInc;
      r_rdValid <= w_pop;
      if (w_en & w_full)  r_overflow  <= 1'b1;
      if (r_en & r_empty) r_underflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvlInc;
        2'b01:   r_level <= r_level - c_lvlInc;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire
